control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle successor to the single-cycle control top: sequences each instruction through
//  FETCH/DECODE/EXECUTE/MEMORY/IO_WAIT/WRITEBACK and holds per-mode banked NZCV flags.
//  Also evaluates branch conditions and handshakes with memory and the board I/O buttons,
//  with an optional I/O timeout. Sits between the instruction decoder and the datapath.
// PARAMETERS
//  ID_WIDTH          7  width of decoded instruction ID (passed through, latched at DECODE)
//  NUM_MODES         2  number of processor modes, each with its own banked NZCV set (>=1)
//  IO_TIMEOUT_WIDTH  0  I/O timeout counter width; 0 = no timeout (wait forever)
// PORTS
//  clock             in   1   system clock, rising edge
//  reset             in   1   asynchronous, active-high
//  instr_id          in   ID_WIDTH  decoded instruction ID
//  instr_class       in   3   0 ALU,1 SHIFT,2 LOAD,3 STORE,4 BRANCH,5 INPUT,6 OUTPUT,7 HALT
//  condition_code    in   4   ARM cond code; 14 = always, 15 = never
//  flag_update_mode  in   2   0 none, 1 ALU NZCV, 2 shifter NZC (V kept), 3 none
//  alu_flags         in   4   {N,Z,C,V} from ALU
//  bs_flags          in   3   {N,Z,C} from barrel shifter
//  mode_switch       in   1   request mode change at WRITEBACK
//  new_mode          in   MW  requested mode, MW = max(1,$clog2(NUM_MODES))
//  mem_ready         in   1   memory completes access this cycle
//  confirmation      in   1   input-accept button, level, already synchronised
//  continue_button   in   1   output-continue button, level, already synchronised
//  state             out  3   current FSM state (debug/LEDs)
//  latched_id        out  ID_WIDTH  instr_id captured in DECODE
//  ir_load           out  1   load instruction register
//  pc_enable         out  1   advance/branch PC
//  regfile_write_en  out  1   register file write strobe
//  mem_write_en      out  1   memory write strobe
//  is_input, is_output out 1 each  I/O phase indicators
//  should_take_branch out 1   registered branch decision
//  flags             out  4   {N,Z,C,V} of current mode's bank
//  mode              out  MW  current mode
//  io_timeout        out  1   sticky: an I/O wait expired
//  halted            out  1   HALT state reached
// BEHAVIOUR
//  - Reset: state=FETCH, all flag banks=0, mode=0, io_timeout=0, latched_id=0, all strobes 0;
//    button history regs reset to 1 (a button held through reset does not count as a press).
//  - FETCH (1 cyc): ir_load=1 -> DECODE (1 cyc): latch instr_id/class/cond/update/mode req -> EXECUTE.
//  - EXECUTE (1 cyc): should_take_branch <= (class==BRANCH) & cond(flags); held until next EXECUTE.
//    Next: LOAD/STORE->MEMORY; INPUT/OUTPUT->IO_WAIT; HALT->HALTED; else->WRITEBACK.
//  - MEMORY: mem_write_en=1 each cycle while class==STORE; stay until mem_ready=1 -> WRITEBACK.
//  - IO_WAIT: is_input (INPUT) or is_output (OUTPUT) held high. Exit on rising edge
//    (prev=0, now=1) of confirmation (INPUT) or continue_button (OUTPUT). Edges are detected
//    every cycle but only consumed in IO_WAIT; an edge in the entry cycle does count.
//  - Timeout (IO_TIMEOUT_WIDTH>0): counter cleared on IO_WAIT entry; at 2^W-1 cycles with no
//    edge: set io_timeout, go WRITEBACK with regfile_write_en suppressed. Edge and expiry in
//    the same cycle: edge wins.
//  - WRITEBACK (1 cyc): pc_enable=1; regfile_write_en=1 for ALU,SHIFT,LOAD,INPUT; flags update
//    into current-mode bank per update mode; then mode<=new_mode if mode_switch and
//    new_mode<NUM_MODES (else ignored). Flags written to the old mode's bank. -> FETCH.
//  - HALTED: absorbing; only reset exits; halted=1, all strobes 0.
//  - Latency: non-memory, non-I/O instruction = 4 cycles; LOAD/STORE = 4 + mem wait.
//  - Conditions (N,Z,C,V of current bank): 0 EQ Z,1 NE !Z,2 CS C,3 CC !C,4 MI N,5 PL !N,6 VS V,
//    7 VC !V,8 HI C&!Z,9 LS !C|Z,10 GE N==V,11 LT N!=V,12 GT !Z&N==V,13 LE Z|N!=V,14 1,15 0.
//  - Reset mid-operation: immediate return to FETCH, strobes deasserted asynchronously.
//  - All strobes are Moore outputs decoded from registered state/latched class (glitch-free).
// STRUCTURE
//  - control_sequencer_pkg: state encoding, instr_class codes, flag update codes, cond codes.
//  - Sub-module condition_evaluator (combinational, cond+NZCV -> take); FSM, flag banks,
//    edge detectors and timeout counter live in the top.
// TESTING
//  - ALU, update=1, alu_flags=4'b0100: FETCH..WRITEBACK in 4 cycles, flags=0100, rfw pulse 1 cyc.
//  - BRANCH cond=0 with Z=1 -> should_take_branch=1; cond=1 -> 0; cond=15 -> 0 always.
//  - STORE, mem_ready low 3 cycles: mem_write_en high exactly 4 cycles, no regfile_write_en.
//  - INPUT, confirmation held high from reset: no exit until released and re-pressed.
//  - IO_TIMEOUT_WIDTH=3, OUTPUT, no button: WRITEBACK after 7 cycles, io_timeout=1, sticky.
//  - NUM_MODES=2: set flags in mode 0, switch to 1: flags=0; switch back: mode-0 flags restored;
//    new_mode=2 with NUM_MODES=2 ignored. HALT then reset mid-HALTED -> FETCH.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states,
// instruction classes, flag-update modes and ARM condition codes.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_IO_WAIT   = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALTED    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_SHIFT  = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4,
    CL_INPUT  = 3'd5,
    CL_OUTPUT = 3'd6,
    CL_HALT   = 3'd7
  } instr_class_t;

  localparam logic [1:0] UPD_NONE  = 2'd0;
  localparam logic [1:0] UPD_ALU   = 2'd1;
  localparam logic [1:0] UPD_SHIFT = 2'd2;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Classes that produce a register-file result at WRITEBACK.
  function automatic logic writes_reg(instr_class_t c);
    return (c == CL_ALU) || (c == CL_SHIFT) || (c == CL_LOAD) || (c == CL_INPUT);
  endfunction

endpackage

// File: rtl/control_sequencer_condition_evaluator.sv
// Combinational ARM condition evaluator.
//   cond  in  4  condition code (14 always, 15 never)
//   nzcv  in  4  {N,Z,C,V}
//   take  out 1  condition holds
module condition_evaluator
  import control_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       take
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_EQ: take = z;
      COND_NE: take = !z;
      COND_CS: take = c;
      COND_CC: take = !c;
      COND_MI: take = n;
      COND_PL: take = !n;
      COND_VS: take = v;
      COND_VC: take = !v;
      COND_HI: take = c && !z;
      COND_LS: take = !c || z;
      COND_GE: take = (n == v);
      COND_LT: take = (n != v);
      COND_GT: take = !z && (n == v);
      COND_LE: take = z || (n != v);
      COND_AL: take = 1'b1;
      default: take = 1'b0;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer. Walks each instruction through
// FETCH/DECODE/EXECUTE/(MEMORY|IO_WAIT)/WRITEBACK, keeps one NZCV bank per
// processor mode, registers the branch decision and handshakes with memory
// and the board buttons (optional I/O timeout).
// Ports:
//   clock, reset                    clock, async active-high reset
//   instr_id/class/condition_code   decoded instruction, latched in DECODE
//   flag_update_mode, alu_flags, bs_flags  flag sources applied at WRITEBACK
//   mode_switch, new_mode           mode change request, latched in DECODE
//   mem_ready, confirmation, continue_button  handshakes
//   state, latched_id               debug
//   ir_load, pc_enable, regfile_write_en, mem_write_en, is_input, is_output  strobes
//   should_take_branch, flags, mode, io_timeout, halted  status
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int ID_WIDTH         = 7,
  parameter int NUM_MODES        = 2,
  parameter int IO_TIMEOUT_WIDTH = 0,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ID_WIDTH-1:0] instr_id,
  input  logic [2:0]          instr_class,
  input  logic [3:0]          condition_code,
  input  logic [1:0]          flag_update_mode,
  input  logic [3:0]          alu_flags,
  input  logic [2:0]          bs_flags,
  input  logic                mode_switch,
  input  logic [MW-1:0]       new_mode,
  input  logic                mem_ready,
  input  logic                confirmation,
  input  logic                continue_button,
  output logic [2:0]          state,
  output logic [ID_WIDTH-1:0] latched_id,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                regfile_write_en,
  output logic                mem_write_en,
  output logic                is_input,
  output logic                is_output,
  output logic                should_take_branch,
  output logic [3:0]          flags,
  output logic [MW-1:0]       mode,
  output logic                io_timeout,
  output logic                halted
);
  // Counter exists even without a timeout so the datapath stays uniform;
  // expiry is then constant-false and the counter folds away.
  localparam int TW = (IO_TIMEOUT_WIDTH > 0) ? IO_TIMEOUT_WIDTH : 1;
  // Count starts at 0 in the first IO_WAIT cycle, so the (2^W-1)th cycle sees 2^W-2.
  localparam logic [TW-1:0] TMO_LAST = TW'((2 ** TW) - 2);

  state_t                     state_q, state_n;
  instr_class_t               lat_class;
  logic [3:0]                 lat_cond;
  logic [1:0]                 lat_upd;
  logic                       lat_msw;
  logic [MW-1:0]              lat_nmode;
  logic [NUM_MODES-1:0][3:0]  bank;
  logic                       conf_prev, cont_prev;
  logic [TW-1:0]              tmo_cnt;
  logic                       timed_out_now;
  logic                       cond_take, io_edge, expire;

  assign flags = bank[mode];
  assign state = state_q;

  condition_evaluator u_cond (
    .cond (lat_cond),
    .nzcv (flags),
    .take (cond_take)
  );

  // Edges are computed every cycle; only IO_WAIT looks at them.
  assign io_edge = (lat_class == CL_INPUT) ? (confirmation && !conf_prev)
                                           : (continue_button && !cont_prev);
  assign expire  = (IO_TIMEOUT_WIDTH > 0) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_FETCH:   state_n = ST_DECODE;
      ST_DECODE:  state_n = ST_EXECUTE;
      ST_EXECUTE: begin
        case (lat_class)
          CL_LOAD, CL_STORE:   state_n = ST_MEMORY;
          CL_INPUT, CL_OUTPUT: state_n = ST_IO_WAIT;
          CL_HALT:             state_n = ST_HALTED;
          default:             state_n = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY:    if (mem_ready) state_n = ST_WRITEBACK;
      ST_IO_WAIT:   if (io_edge || expire) state_n = ST_WRITEBACK;
      ST_WRITEBACK: state_n = ST_FETCH;
      ST_HALTED:    state_n = ST_HALTED;
      default:      state_n = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= ST_FETCH;
      lat_class          <= CL_ALU;
      lat_cond           <= '0;
      lat_upd            <= UPD_NONE;
      lat_msw            <= 1'b0;
      lat_nmode          <= '0;
      latched_id         <= '0;
      should_take_branch <= 1'b0;
      bank               <= '0;
      mode               <= '0;
      io_timeout         <= 1'b0;
      timed_out_now      <= 1'b0;
      tmo_cnt            <= '0;
      // A button held through reset must not look like a fresh press.
      conf_prev          <= 1'b1;
      cont_prev          <= 1'b1;
    end else begin
      state_q   <= state_n;
      conf_prev <= confirmation;
      cont_prev <= continue_button;
      case (state_q)
        ST_DECODE: begin
          latched_id <= instr_id;
          lat_class  <= instr_class_t'(instr_class);
          lat_cond   <= condition_code;
          lat_upd    <= flag_update_mode;
          lat_msw    <= mode_switch;
          lat_nmode  <= new_mode;
        end
        ST_EXECUTE: begin
          should_take_branch <= (lat_class == CL_BRANCH) && cond_take;
          tmo_cnt            <= '0;
          timed_out_now      <= 1'b0;
        end
        ST_IO_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          // A press in the expiry cycle wins over the timeout.
          if (!io_edge && expire) begin
            io_timeout    <= 1'b1;
            timed_out_now <= 1'b1;
          end
        end
        ST_WRITEBACK: begin
          // Flags land in the bank of the mode that executed the instruction.
          case (lat_upd)
            UPD_ALU:   bank[mode] <= alu_flags;
            UPD_SHIFT: bank[mode] <= {bs_flags, bank[mode][0]};
            default:   ;
          endcase
          if (lat_msw && (int'(lat_nmode) < NUM_MODES)) mode <= lat_nmode;
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded from registered state only; gating with reset drops
  // them immediately, including the FETCH-state ir_load during reset.
  assign ir_load          = !reset && (state_q == ST_FETCH);
  assign pc_enable        = !reset && (state_q == ST_WRITEBACK);
  assign regfile_write_en = !reset && (state_q == ST_WRITEBACK) && writes_reg(lat_class)
                            && !timed_out_now;
  assign mem_write_en     = !reset && (state_q == ST_MEMORY) && (lat_class == CL_STORE);
  assign is_input         = !reset && (state_q == ST_IO_WAIT) && (lat_class == CL_INPUT);
  assign is_output        = !reset && (state_q == ST_IO_WAIT) && (lat_class == CL_OUTPUT);
  assign halted           = !reset && (state_q == ST_HALTED);

endmodule
